// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB command arbiter.
package apb_arb_pkg;

    localparam int ARB_ADDR_W = 8;
    localparam int ARB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NREQ.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic found;
    int   j;

    // Scan NREQ positions starting from the pointer; keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr_i) + i) % NREQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PTR_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing the APB master command port among NREQ
// requesters, one transfer in flight at a time.
// Optional completion watchdog: define APB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; grants one and latches its command
// ISSUE | transfer asserted, waiting for the bus to select the slave
// WAIT  | access phase, waiting for Psel & Penable & Pready
// RESP  | one-cycle rsp_valid pulse to the winner, pointer advances
module apb_cmd_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   Pclk,
    input  logic                   Preset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_slverr,
    output logic                   transfer,
    output logic                   WRITE_READ,
    output logic [ADDR_W-1:0]      APB_write_paddr,
    output logic [ADDR_W-1:0]      APB_read_paddr,
    output logic [DATA_W-1:0]      APB_write_data,
    input  logic                   Psel,
    input  logic                   Penable,
    input  logic                   Pready,
    input  logic [DATA_W-1:0]      Prdata_out,
    input  logic                   slverr_out
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               slverr_q, slverr_d;

    logic [NREQ-1:0]    pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic               tmo_hit;
    logic               apb_done;

    apb_rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign apb_done = Psel & Penable & Pready;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == '0);

    // Down-counter reloaded on accept; terminal count ends the transfer.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE && pick_any) begin
            tmo_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
        end else if ((state_q == ISSUE || state_q == WAIT) && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign tmo_hit        = 1'b0;
`endif

    // Next-state and datapath latch logic.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    write_d = req_write[pick_idx];
                    addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = req_write[pick_idx] ? req_wdata[pick_idx*DATA_W +: DATA_W] : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (tmo_hit) begin
                    rdata_d  = '0;
                    slverr_d = 1'b1;
                    state_d  = RESP;
                end else if (Psel) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A real completion wins over a watchdog expiry in the same cycle.
                if (apb_done) begin
                    rdata_d  = write_q ? '0 : Prdata_out;
                    slverr_d = slverr_out;
                    state_d  = RESP;
                end else if (tmo_hit) begin
                    rdata_d  = '0;
                    slverr_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and latched command/response registers.
    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
        end
    end

    // req_ready is combinational, so it is masked while reset is held.
    assign req_ready       = (state_q == IDLE && !Preset) ? pick_gnt : '0;
    assign rsp_valid       = (state_q == RESP) ? (NREQ'(1) << idx_q) : '0;
    assign rsp_rdata       = rdata_q;
    assign rsp_slverr      = slverr_q;
    assign transfer        = (state_q == ISSUE);
    assign WRITE_READ      = write_q;
    assign APB_write_paddr = addr_q;
    assign APB_read_paddr  = addr_q;
    assign APB_write_data  = wdata_q;

endmodule
